// File: rtl/mult_pkg.sv
// Shared constants for the shift-add multiplier control path.
// Holds the default operand width, counter width and FSM state encodings.
package mult_pkg;

  localparam int N_DEF  = 4;
  localparam int CW_DEF = 3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLRD  = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_ADD   = 3'd3;
  localparam logic [2:0] S_SHIFT = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

endpackage

// File: rtl/mult_iter_cnt.sv
// Iteration counter for the multiplier FSM: synchronous zero-load,
// increment enable and a flag raised on the final iteration.
module mult_iter_cnt #(
  parameter int N  = 4,
  parameter int CW = 3
) (
  input  logic clk,
  input  logic clr,
  input  logic zero,
  input  logic inc,
  output logic last
);

  logic [CW-1:0] cnt;

  // Reloaded on every operand load, so it never has to saturate.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt <= '0;
    end else if (zero) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign last = (cnt == CW'(N - 1));

endmodule

// File: rtl/mult_ctrl.sv
// Moore control FSM for the 4-bit shift-add multiplier datapath.
// All strobes decode from the registered state only.
module mult_ctrl
  import mult_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int CW = CW_DEF
) (
  input  logic clk,
  input  logic clr,
  input  logic start,
  output logic clr_dp,
  output logic ld,
  output logic ldp,
  output logic shp,
  output logic shb,
  output logic busy,
  output logic done
);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       last;

  mult_iter_cnt #(
    .N  (N),
    .CW (CW)
  ) u_iter_cnt (
    .clk  (clk),
    .clr  (clr),
    .zero (state == S_LOAD),
    .inc  (state == S_SHIFT),
    .last (last)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Unused encodings fall back to IDLE on the next edge.
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:  state_nxt = start ? S_CLRD : S_IDLE;
      S_CLRD:  state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_ADD;
      S_ADD:   state_nxt = S_SHIFT;
      S_SHIFT: state_nxt = last ? S_DONE : S_ADD;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    clr_dp = 1'b0;
    ld     = 1'b0;
    ldp    = 1'b0;
    shp    = 1'b0;
    shb    = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (state)
      S_CLRD: begin
        clr_dp = 1'b1;
        busy   = 1'b1;
      end
      S_LOAD: begin
        ld   = 1'b1;
        busy = 1'b1;
      end
      S_ADD: begin
        ldp  = 1'b1;
        busy = 1'b1;
      end
      S_SHIFT: begin
        shp  = 1'b1;
        shb  = 1'b1;
        busy = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
        busy = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mult_ctrl.sv
// Bench for mult_ctrl with a small behavioural shift-add datapath attached.
// Directed operations with hand-computed products, latencies and strobe order.
module tb_mult_ctrl;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic start = 1'b0;
  logic clr_dp, ld, ldp, shp, shb, busy, done;

  logic [3:0] da = '0, db = '0;
  logic [3:0] ra, rb;
  logic [7:0] p;
  logic       c;

  int checks = 0;
  int failures = 0;
  bit monOn = 1'b0;
  int seq [0:10];
  int lat;

  always #5 clk = ~clk;

  mult_ctrl dut (
    .clk    (clk),
    .clr    (clr),
    .start  (start),
    .clr_dp (clr_dp),
    .ld     (ld),
    .ldp    (ldp),
    .shp    (shp),
    .shb    (shb),
    .busy   (busy),
    .done   (done)
  );

  // Reference datapath: 4-bit adder into the upper product half plus carry.
  always_ff @(posedge clk) begin
    if (clr_dp) begin
      ra <= '0;
      rb <= '0;
      p  <= '0;
      c  <= 1'b0;
    end else begin
      if (ld) begin
        ra <= da;
        rb <= db;
      end
      if (ldp) {c, p[7:4]} <= {1'b0, p[7:4]} + {1'b0, (rb[0] ? ra : 4'd0)};
      if (shp) {c, p} <= {1'b0, c, p[7:1]};
      if (shb) rb <= rb >> 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int strobeCode();
    if (clr_dp) return 1;
    if (ld) return 2;
    if (ldp) return 3;
    if (shp) return 4;
    if (done) return 5;
    return 0;
  endfunction

  // Mutual exclusion checks sampled every cycle away from the active edge.
  always @(negedge clk) begin
    if (monOn) begin
      checkOutput("onehot", 32'($countones({clr_dp, ld, ldp, shp}) <= 1), 1);
      checkOutput("shb_eq_shp", {31'd0, shb ^ shp}, 0);
      checkOutput("done_excl", {31'd0, done & (clr_dp | ld | ldp | shp | ~busy)}, 0);
    end
  end

  // Runs one operation; lat counts cycles from the start edge to the done cycle.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b);
    int idx;
    int code;
    bit seen;
    da = a;
    db = b;
    idx = 0;
    seen = 1'b0;
    for (int i = 0; i < 11; i++) seq[i] = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    lat = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      code = strobeCode();
      if (code != 0 && idx < 11) begin
        seq[idx] = code;
        idx++;
      end
      if (done) seen = 1'b1;
    end
    if (!seen) checkOutput("done_timeout", 0, 1);
  endtask

  int expSeq [0:10] = '{1, 2, 3, 4, 3, 4, 3, 4, 3, 4, 5};
  logic [3:0] va [0:3] = '{4'd13, 4'hF, 4'h0, 4'h1};
  logic [3:0] vb [0:3] = '{4'd11, 4'hF, 4'h9, 4'h1};
  logic [7:0] vp [0:3] = '{8'd143, 8'd225, 8'd0, 8'd1};

  initial begin
    int doneCnt;
    int donePos [0:3];
    int busyLow;
    bit sawDone;

    repeat (2) @(negedge clk);
    checkOutput("reset_outs", {25'd0, clr_dp, ld, ldp, shp, shb, busy, done}, 0);
    clr = 1'b0;
    monOn = 1'b1;
    @(negedge clk);
    checkOutput("idle_outs", {25'd0, clr_dp, ld, ldp, shp, shb, busy, done}, 0);

    // Basic op and corner operands through the attached datapath.
    for (int v = 0; v < 4; v++) begin
      applyStimulus(va[v], vb[v]);
      checkOutput($sformatf("latency%0d", v), 32'(lat), 11);
      checkOutput($sformatf("product%0d", v), {24'd0, p}, {24'd0, vp[v]});
      if (v == 0)
        for (int i = 0; i < 11; i++)
          checkOutput($sformatf("order%0d", i), 32'(seq[i]), 32'(expSeq[i]));
      @(negedge clk);
      checkOutput($sformatf("busy_after%0d", v), {31'd0, busy}, 0);
    end

    // Asynchronous reset mid-SHIFT drops every output within the cycle.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && !shp; i++) @(negedge clk);
    checkOutput("reached_shift", {31'd0, shp}, 1);
    monOn = 1'b0;
    #1 clr = 1'b1;
    #1 checkOutput("async_clr", {25'd0, clr_dp, ld, ldp, shp, shb, busy, done}, 0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("held_clr", {25'd0, clr_dp, ld, ldp, shp, shb, busy, done}, 0);
    end
    clr = 1'b0;
    monOn = 1'b1;
    sawDone = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy) sawDone = 1'b1;
    end
    checkOutput("no_done_after_clr", {31'd0, sawDone}, 0);

    // A start pulse at the second ADD is ignored.
    da = 4'd5;
    db = 4'd3;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    doneCnt = 0;
    for (int i = 0, n = 0; i < 40; i++) begin
      if (ldp) begin
        n++;
        if (n == 2) start = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      if (done) doneCnt++;
    end
    checkOutput("single_done", 32'(doneCnt), 1);
    checkOutput("busy_end", {31'd0, busy}, 0);
    checkOutput("product_5x3", {24'd0, p}, 24'd0 + 32'd15);

    // start held high for 30 cycles: ops back to back with one idle cycle.
    doneCnt = 0;
    busyLow = 0;
    start = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i == 29) start = 1'b0;
      if (done && doneCnt < 4) begin
        donePos[doneCnt] = i;
        doneCnt++;
      end
      if (!busy && doneCnt >= 1 && doneCnt < 3) busyLow++;
    end
    checkOutput("held_done_count", 32'(doneCnt), 3);
    if (doneCnt >= 3) begin
      checkOutput("done_gap1", 32'(donePos[1] - donePos[0]), 12);
      checkOutput("done_gap2", 32'(donePos[2] - donePos[1]), 12);
    end
    checkOutput("idle_between", 32'(busyLow), 2);

    monOn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got 0, expected 1");
    $fatal(1, "[TB] timeout");
  end

endmodule
